// File: rtl/sram_burst_arbiter_if.sv
`timescale 1ns/1ps
// Requester-side and SRAM-side signals of the burst arbiter, bundled so the
// arbiter (slave view) and its environment (master view) share one port.
interface sram_burst_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 48,
  parameter int LEN_W  = 4
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_done;
  logic [DATA_W-1:0]        rdata;
  logic                     err;
  logic                     sram_read_enable;
  logic                     sram_write_enable;
  logic [ADDR_W-1:0]        sram_address;
  logic [DATA_W-1:0]        sram_write_data;
  logic [DATA_W-1:0]        sram_read_data;

  modport slave (
    input  ch_req, ch_write, ch_addr, ch_len, ch_wdata, sram_read_data,
    output ch_grant, ch_ack, ch_done, rdata, err,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

  modport master (
    output ch_req, ch_write, ch_addr, ch_len, ch_wdata, sram_read_data,
    input  ch_grant, ch_ack, ch_done, rdata, err,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_burst_arbiter.sv
`timescale 1ns/1ps
// Round-robin burst arbiter in front of the SRAM wrapper: multi-beat bursts
// with wait states, a one-cycle gap per beat, and abort reporting.
module sram_burst_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 48,
  parameter int LEN_W       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 n_rst,
  sram_burst_arbiter_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   pick_idx;
  logic [CH_W-1:0]   cur_idx;
  logic              pick_vld;
  logic              pick_write;
  logic [ADDR_W-1:0] pick_addr;
  logic [LEN_W-1:0]  pick_len;
  logic [NUM_CH-1:0] pick_oh;
  logic [NUM_CH-1:0] gnt_oh;
  logic              write_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  beat_nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] cur_wdata;
  logic              req_g;
  logic              last_beat;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_vld && bus.ch_req[(int'(rr_ptr) + i) % NUM_CH]) begin
        pick_vld = 1'b1;
        pick_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  assign pick_oh    = NUM_CH'(1) << pick_idx;
  assign gnt_oh     = NUM_CH'(1) << gnt_idx;
  assign pick_write = bus.ch_write[pick_idx];
  assign pick_addr  = bus.ch_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
  assign pick_len   = bus.ch_len[int'(pick_idx) * LEN_W +: LEN_W];
  assign cur_idx    = (state == IDLE) ? pick_idx : gnt_idx;
  assign cur_wdata  = bus.ch_wdata[int'(cur_idx) * DATA_W +: DATA_W];
  assign req_g      = bus.ch_req[gnt_idx];
  assign last_beat  = (beat_q == len_q);
  assign beat_nxt   = beat_q + 1'b1;
  assign nxt_addr   = base_q + {{(ADDR_W-LEN_W){1'b0}}, beat_nxt};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                 <= IDLE;
      rr_ptr                <= '0;
      gnt_idx               <= '0;
      write_q               <= 1'b0;
      base_q                <= '0;
      len_q                 <= '0;
      beat_q                <= '0;
      wait_cnt              <= '0;
      bus.ch_grant          <= '0;
      bus.ch_ack            <= '0;
      bus.ch_done           <= '0;
      bus.err               <= 1'b0;
      bus.rdata             <= '0;
      bus.sram_read_enable  <= 1'b0;
      bus.sram_write_enable <= 1'b0;
      bus.sram_address      <= '0;
      bus.sram_write_data   <= '0;
    end else begin
      bus.ch_ack  <= '0;
      bus.ch_done <= '0;
      bus.err     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state                 <= ACCESS;
            gnt_idx               <= pick_idx;
            rr_ptr                <= CH_W'((int'(pick_idx) + 1) % NUM_CH);
            write_q               <= pick_write;
            base_q                <= pick_addr;
            len_q                 <= pick_len;
            beat_q                <= '0;
            wait_cnt              <= '0;
            bus.ch_grant          <= pick_oh;
            bus.sram_read_enable  <= !pick_write;
            bus.sram_write_enable <= pick_write;
            bus.sram_address      <= pick_addr;
            bus.sram_write_data   <= pick_write ? cur_wdata : '0;
          end
        end
        ACCESS: begin
          if (!req_g) begin
            state                 <= IDLE;
            bus.err               <= 1'b1;
            bus.ch_grant          <= '0;
            bus.sram_read_enable  <= 1'b0;
            bus.sram_write_enable <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state                 <= GAP;
            bus.sram_read_enable  <= 1'b0;
            bus.sram_write_enable <= 1'b0;
            bus.ch_ack            <= gnt_oh;
            bus.ch_done           <= last_beat ? gnt_oh : '0;
            if (!write_q) bus.rdata <= bus.sram_read_data;
          end else begin
            // Write data keeps tracking the requester so the committing cycle sees this beat's word.
            wait_cnt <= wait_cnt + 1'b1;
            if (write_q) bus.sram_write_data <= cur_wdata;
          end
        end
        GAP: begin
          if (last_beat) begin
            state        <= IDLE;
            bus.ch_grant <= '0;
          end else if (!req_g) begin
            state        <= IDLE;
            bus.err      <= 1'b1;
            bus.ch_grant <= '0;
          end else begin
            state                 <= ACCESS;
            beat_q                <= beat_nxt;
            wait_cnt              <= '0;
            bus.sram_read_enable  <= !write_q;
            bus.sram_write_enable <= write_q;
            bus.sram_address      <= nxt_addr;
            if (write_q) bus.sram_write_data <= cur_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_burst_arbiter.sv
`timescale 1ns/1ps
// Bench for sram_burst_arbiter: table rows, corner sequences (round-robin,
// abort, async reset) and randomized rounds against a rule-based timing model.
module tb_sram_burst_arbiter;
  localparam int NUM_CH      = 2;
  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 48;
  localparam int LEN_W       = 4;
  localparam int WAIT_CYCLES = 1;
  localparam int PERIOD      = WAIT_CYCLES + 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sram_burst_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sram_burst_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  // SRAM model: read data equals the address being read.
  assign bus.sram_read_data = DATA_W'(bus.sram_address);

  typedef struct {
    int                ch;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    int                len;
    logic [DATA_W-1:0] data;
    int                exp_acks;
    int                exp_gcyc;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int model_rr;
  logic              d_wr   [NUM_CH];
  logic [ADDR_W-1:0] d_addr [NUM_CH];
  logic [LEN_W-1:0]  d_len  [NUM_CH];
  logic [DATA_W-1:0] d_data [NUM_CH];
  int order_q[$];
  int obs_acks;
  int obs_gcyc;
  logic [ADDR_W-1:0] obs_last_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, bus.ch_grant, 0);
    chk({tag, "_ack"}, bus.ch_ack, 0);
    chk({tag, "_done"}, bus.ch_done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_re"}, bus.sram_read_enable, 0);
    chk({tag, "_we"}, bus.sram_write_enable, 0);
    chk({tag, "_addr"}, bus.sram_address, 0);
    chk({tag, "_wdata"}, bus.sram_write_data, 0);
  endtask

  task automatic set_ch(input int c);
    bus.ch_write[c] = d_wr[c];
    bus.ch_addr[c*ADDR_W +: ADDR_W] = d_addr[c];
    bus.ch_len[c*LEN_W +: LEN_W] = d_len[c];
    bus.ch_wdata[c*DATA_W +: DATA_W] = d_data[c];
    bus.ch_req[c] = 1'b1;
  endtask

  // Entered just after a rising edge. Requests every channel in mask at once and
  // follows each burst cycle by cycle: grant cycle, then per beat WAIT_CYCLES+1
  // access cycles and one ack cycle.
  task automatic run_round(input logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] pending;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    int ch, tlen, k, p, g;
    pending = mask;
    obs_acks = 0;
    obs_gcyc = 0;
    obs_last_addr = '0;
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) set_ch(c);
    for (int n = 0; n < NUM_CH && pending != 0; n++) begin
      ch = -1;
      for (int i = 0; i < NUM_CH; i++)
        if (ch < 0 && pending[(model_rr + i) % NUM_CH]) ch = (model_rr + i) % NUM_CH;
      model_rr = (ch + 1) % NUM_CH;
      tlen = 1 + (int'(d_len[ch]) + 1) * PERIOD;
      k = 0;
      p = 0;
      for (int t = 0; t < tlen; t++) begin
        @(negedge clk);
        chk("err_quiet", bus.err, 0);
        if (t == 0) begin
          chk("idle_grant", bus.ch_grant, 0);
          chk("idle_re", bus.sram_read_enable, 0);
          chk("idle_we", bus.sram_write_enable, 0);
        end else begin
          k  = (t - 1) / PERIOD;
          p  = (t - 1) % PERIOD;
          ea = d_addr[ch] + ADDR_W'(k);
          ed = d_data[ch] + DATA_W'(k);
          if (t == 1) begin
            g = -1;
            for (int c = 0; c < NUM_CH; c++) if (bus.ch_grant[c]) g = c;
            order_q.push_back(g);
          end
          if (bus.ch_grant != 0) obs_gcyc++;
          chk("grant", bus.ch_grant, NUM_CH'(1) << ch);
          chk("addr", bus.sram_address, ea);
          if (p <= WAIT_CYCLES) begin
            chk("access_we", bus.sram_write_enable, d_wr[ch]);
            chk("access_re", bus.sram_read_enable, !d_wr[ch]);
            chk("access_ack", bus.ch_ack, 0);
            if (!d_wr[ch]) chk("wdata_read", bus.sram_write_data, 0);
            else if (p == WAIT_CYCLES || k == 0) chk("wdata", bus.sram_write_data, ed);
          end else begin
            chk("gap_we", bus.sram_write_enable, 0);
            chk("gap_re", bus.sram_read_enable, 0);
            chk("gap_ack", bus.ch_ack, NUM_CH'(1) << ch);
            chk("gap_done", bus.ch_done, (k == int'(d_len[ch])) ? (NUM_CH'(1) << ch) : '0);
            if (bus.ch_ack != 0) obs_acks++;
            obs_last_addr = bus.sram_address;
            if (!d_wr[ch]) chk("rdata", bus.rdata, DATA_W'(ea));
          end
        end
        @(posedge clk);
        #1;
        if (t == 0) begin
          // Post-grant changes to the burst parameters must not matter.
          bus.ch_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          bus.ch_len[ch*LEN_W +: LEN_W] = LEN_W'($urandom);
          bus.ch_write[ch] = ~d_wr[ch];
        end else if (p == PERIOD - 1) begin
          if (k == int'(d_len[ch])) bus.ch_req[ch] = 1'b0;
          else bus.ch_wdata[ch*DATA_W +: DATA_W] = ed + DATA_W'(1);
        end
      end
      pending[ch] = 1'b0;
    end
  endtask

  vec_t vecs[5];
  int   rr_exp[4];

  initial begin
    vecs[0] = '{0, 1'b1, 22'd9,       0,  48'd9,            1,  3,  22'd9};
    vecs[1] = '{0, 1'b0, 22'd8,       3,  48'd0,            4,  12, 22'd11};
    vecs[2] = '{1, 1'b1, 22'h3FFFFF,  1,  48'h0000_1111_22, 2,  6,  22'h000000};
    vecs[3] = '{1, 1'b0, 22'h3FFFFE,  2,  48'd0,            3,  9,  22'h000000};
    vecs[4] = '{1, 1'b1, 22'h001234,  15, 48'hABCD_0000_0100, 16, 48, 22'h001243};
    rr_exp  = '{0, 1, 0, 1};

    bus.ch_req   = '0;
    bus.ch_write = '0;
    bus.ch_addr  = '0;
    bus.ch_len   = '0;
    bus.ch_wdata = '0;
    model_rr     = 0;
    n_rst        = 1'b1;
    #1 n_rst = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Table rows: single-channel bursts
    for (int v = 0; v < 5; v++) begin
      d_wr[vecs[v].ch]   = vecs[v].wr;
      d_addr[vecs[v].ch] = vecs[v].addr;
      d_len[vecs[v].ch]  = LEN_W'(vecs[v].len);
      d_data[vecs[v].ch] = vecs[v].data;
      run_round(NUM_CH'(1) << vecs[v].ch);
      chk("vec_acks", obs_acks, vecs[v].exp_acks);
      chk("vec_grant_cycles", obs_gcyc, vecs[v].exp_gcyc);
      chk("vec_last_addr", obs_last_addr, vecs[v].exp_last);
    end

    // Round-robin: both channels request single beats together, twice
    order_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      d_wr[c] = 1'b1;
      d_addr[c] = ADDR_W'(16 * (c + 1));
      d_len[c] = '0;
      d_data[c] = DATA_W'(100 + c);
    end
    run_round(2'b11);
    run_round(2'b11);
    chk("rr_count", order_q.size(), 4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) chk("rr_order", order_q[i], rr_exp[i]);

    // Abort: ch1 drops its request in the first access cycle of beat 2 while ch0 waits
    d_wr[1] = 1'b1; d_addr[1] = 22'd200; d_len[1] = 4'd3; d_data[1] = 48'hABC;
    set_ch(1);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 4) chk("abort_b1_addr", bus.sram_address, 201);
      @(posedge clk);
      #1;
      if (t == 0) begin
        d_wr[0] = 1'b1; d_addr[0] = 22'd5; d_len[0] = 4'd0; d_data[0] = 48'd77;
        set_ch(0);
      end
    end
    bus.ch_req[1] = 1'b0;
    @(negedge clk);
    chk("abort_access_we", bus.sram_write_enable, 1);
    chk("abort_access_addr", bus.sram_address, 202);
    @(posedge clk); #1; @(negedge clk);
    chk("abort_err", bus.err, 1);
    chk("abort_we", bus.sram_write_enable, 0);
    chk("abort_re", bus.sram_read_enable, 0);
    chk("abort_grant", bus.ch_grant, 0);
    chk("abort_ack", bus.ch_ack, 0);
    chk("abort_done", bus.ch_done, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("abort_err_once", bus.err, 0);
    chk("abort_next_grant", bus.ch_grant, 2'b01);
    chk("abort_next_addr", bus.sram_address, 5);
    @(posedge clk); #1; @(negedge clk);
    chk("abort_next_wdata", bus.sram_write_data, 77);
    @(posedge clk); #1; @(negedge clk);
    chk("abort_next_ack", bus.ch_ack, 2'b01);
    chk("abort_next_done", bus.ch_done, 2'b01);
    @(posedge clk); #1;
    bus.ch_req[0] = 1'b0;
    @(negedge clk);
    chk("abort_end_grant", bus.ch_grant, 0);
    @(posedge clk); #1;
    model_rr = 1;

    // Asynchronous reset in the middle of a write burst
    d_wr[0] = 1'b1; d_addr[0] = 22'd300; d_len[0] = 4'd3; d_data[0] = 48'h55;
    set_ch(0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_we", bus.sram_write_enable, 1);
    #2 n_rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    bus.ch_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_rr = 0;
    @(posedge clk);
    #1;
    d_wr[0] = 1'b0; d_addr[0] = 22'd40; d_len[0] = 4'd1; d_data[0] = '0;
    run_round(2'b01);
    chk("rst_fresh_acks", obs_acks, 2);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        d_wr[c]   = 1'($urandom);
        d_addr[c] = ($urandom_range(0, 3) == 0) ? (22'h3FFFFC + ADDR_W'($urandom_range(0, 3)))
                                                 : ADDR_W'($urandom);
        d_len[c]  = LEN_W'($urandom_range(0, 5));
        d_data[c] = DATA_W'({$urandom, $urandom});
      end
      run_round(NUM_CH'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_burst_arbiter.md
Name: sram_burst_arbiter

Overview:
Multi-channel access controller placed in front of the on-chip SRAM wrapper (read_enable/write_enable/address/read_data/write_data interface). It arbitrates round-robin among NUM_CH requesters in the 2D GPU, for example rasterizer writes and display-scan reads. It issues multi-beat bursts with incrementing addresses and inserts programmable wait states so that SRAM access delays are met. It guarantees the SRAM never sees read and write enabled together, and it reports aborted bursts.

Parameters:
NUM_CH, 2, number of requester channels (>=1)
ADDR_W, 22, SRAM address width
DATA_W, 48, access width (2 words x 3 bytes)
LEN_W, 4, burst length field width; beats = len+1
WAIT_CYCLES, 1, extra cycles each beat holds the SRAM signals (>=0)

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request level; held until ch_done
ch_write  in  NUM_CH  1=write burst, 0=read burst; sampled at grant
ch_addr  in  NUM_CH*ADDR_W  burst start address; sampled at grant
ch_len  in  NUM_CH*LEN_W  beats-1; sampled at grant
ch_wdata  in  NUM_CH*DATA_W  write data for the current beat; sampled live during ACCESS
ch_grant  out  NUM_CH  one-hot; high for the whole burst of the owning channel
ch_ack  out  NUM_CH  1-cycle pulse per completed beat
ch_done  out  NUM_CH  1-cycle pulse coincident with the final ch_ack
rdata  out  DATA_W  read data; valid while ch_ack is high for a read
err  out  1  1-cycle pulse on an aborted burst
sram_read_enable  out  1  to SRAM wrapper
sram_write_enable  out  1  to SRAM wrapper
sram_address  out  ADDR_W  to SRAM wrapper
sram_write_data  out  DATA_W  to SRAM wrapper
sram_read_data  in  DATA_W  from SRAM wrapper

Behaviour:
- Reset (async, n_rst=0): state IDLE, rr pointer=0. All outputs 0, including rdata and the sram_* outputs. The SRAM enables drop immediately, even in the middle of a burst.
- States: IDLE, ACCESS, GAP.
- IDLE:
  - If any ch_req is high, grant the first requesting channel at or after the rr pointer, wrapping.
  - Latch the granted channel's write, addr and len. Set beat=0 and wait_cnt=0. Go to ACCESS next cycle.
  - Set rr pointer = granted channel + 1, mod NUM_CH.
- ACCESS:
  - sram_address = base + beat, mod 2^ADDR_W; no error on wrap.
  - Exactly one of sram_read_enable or sram_write_enable is high, per the latched write bit.
  - sram_write_data = ch_wdata of the granted channel, and 0 for reads.
  - wait_cnt counts 0..WAIT_CYCLES. At WAIT_CYCLES: capture sram_read_data into rdata (reads only) and go to GAP.
- GAP (1 cycle):
  - Both enables low; sram_address and sram_write_data hold.
  - ch_ack[g]=1.
  - If beat==len: ch_done[g]=1, next state IDLE, ch_grant cleared.
  - Otherwise beat+1, next state ACCESS.
- Beat period is WAIT_CYCLES+2 cycles. A burst of N beats occupies 1 + N*(WAIT_CYCLES+2) cycles, counted from the IDLE cycle that grants until the return to IDLE.
- Requester contract:
  - Present the next ch_wdata on the clock edge that ends the ack cycle.
  - Clear ch_req on the edge that ends the done cycle. IDLE then never re-grants a completed request.
- Abort: ch_req[g] low during ACCESS, or during a non-final GAP.
  - Enables go low next cycle, err pulses 1 cycle, no further ch_ack, no ch_done.
  - Return to IDLE; the rr pointer is already advanced.
- Simultaneous requests: serviced in round-robin order with no starvation. A channel requesting during another channel's burst waits for IDLE.
- Changes to ch_write, ch_addr or ch_len after grant are ignored.
- Outputs ch_grant, ch_ack, ch_done, err, rdata and the sram_* signals are all registered.

Test Plan:
1. Single write, WAIT_CYCLES=1, ch0 write addr 9, data 9, len 0:
   - sram_write_enable high for 2 cycles with address 9 and write_data 9.
   - Then GAP with ch_ack[0]=ch_done[0]=1.
   - Total 4 cycles, starting from the granting IDLE cycle.
2. Read burst, ch0 addr 8, len 3, SRAM model returning data=address:
   - Addresses 8, 9, 10, 11.
   - rdata 8, 9, 10, 11 on the four ch_ack pulses; ch_done on the 4th.
   - sram_write_enable is never high.
3. Round-robin, ch0 and ch1 both request single beats at the same time, then both re-request:
   - Order ch0, ch1, ch0, ch1.
   - ch_grant is one-hot and never overlaps.
4. Wrap, addr 0x3FFFFF, len 1:
   - Addresses 0x3FFFFF then 0x000000.
   - Two acks, no err.
5. Abort, ch1 4-beat write, ch1 drops ch_req during beat 2 ACCESS, ch0 pending:
   - Enables low next cycle, err pulse 1 cycle, no ch_done[1].
   - ch0 granted from the following IDLE.
6. Reset mid-burst: n_rst low during ACCESS of a write:
   - sram_write_enable and all other outputs 0 without waiting for a clock edge.
   - After release, IDLE; a fresh request completes normally.
